// File: rtl/aes_controller.sv
// aes_controller: control FSM for an iterative AES-128 encryption datapath.
// Takes a key beat and then a plaintext beat over a valid/ready handshake.
// It then steps the datapath through ten rounds of EXP/ARK/SUB/SHR/WB,
// runs a final key expansion and AddRoundKey, and pulses done for one cycle.
//
// Optional feature: define AES_CTRL_CMP_CHECK_EN to check the datapath
// round comparator (equ) and latch a sticky err on a mismatch. With the
// macro undefined, err is tied to 0 and equ/less/gt are ignored.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready 128-bit beat handshake (key beat first, then text beat)
//   equ, less, gt       datapath round-comparator flags
//   sel1, sel2, sel3    datapath mux selects
//   ld*                 datapath register load enables
//   busy, done, round   status: busy outside IDLE, one-cycle done, round 0..10
//   err                 sticky comparator-mismatch flag
module aes_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       equ,
    input  logic       less,
    input  logic       gt,
    output logic       sel1,
    output logic       sel2,
    output logic       sel3,
    output logic       ldText,
    output logic       ldKey,
    output logic       ldExpanded,
    output logic       ldTextAfterAddRoundKey,
    output logic       ldTextAfterSubBytes,
    output logic       ldTextAfterShiftRows,
    output logic       busy,
    output logic       done,
    output logic [3:0] round,
    output logic       err
);

    localparam int unsigned ROUND_W = 4;
    localparam logic [ROUND_W-1:0] LAST_MIX_ROUND = ROUND_W'(9);
    localparam logic [ROUND_W-1:0] FINAL_ROUND    = ROUND_W'(10);

    typedef enum logic [3:0] {
        IDLE, KEYCAP, WAITTXT, EXP, ARK, SUB, SHR, WB, FEXP, FARK, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               ld_text_wb;
    logic               accept_c;

    // in_ready is only ever high in IDLE/WAITTXT, so this marks a beat accepted there
    assign accept_c = in_valid & in_ready;

    // The input-beat load must land on the accepting edge; the WB load is registered
    assign ldText = ld_text_wb | accept_c;
    assign round  = round_q;

    // Next-state and round counter
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            IDLE: begin
                round_d = '0;
                if (accept_c) state_d = KEYCAP;
            end
            KEYCAP:  state_d = WAITTXT;
            WAITTXT: begin
                if (accept_c) begin
                    state_d = EXP;
                    round_d = '0;
                end
            end
            EXP: state_d = ARK;
            ARK: state_d = SUB;
            SUB: state_d = SHR;
            SHR: state_d = WB;
            WB: begin
                round_d = round_q + ROUND_W'(1);
                state_d = (round_q == LAST_MIX_ROUND) ? FEXP : EXP;
            end
            FEXP: state_d = FARK;
            FARK: state_d = DONE;
            DONE: begin
                state_d = IDLE;
                round_d = '0;
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
            end
        endcase
    end

    // State register; outputs are decoded from the next state so each one is
    // a flop that is valid for the whole cycle the FSM spends in that state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q                <= IDLE;
            round_q                <= '0;
            in_ready               <= 1'b0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            sel1                   <= 1'b0;
            sel2                   <= 1'b0;
            sel3                   <= 1'b0;
            ld_text_wb             <= 1'b0;
            ldKey                  <= 1'b0;
            ldExpanded             <= 1'b0;
            ldTextAfterAddRoundKey <= 1'b0;
            ldTextAfterSubBytes    <= 1'b0;
            ldTextAfterShiftRows   <= 1'b0;
        end else begin
            state_q                <= state_d;
            round_q                <= round_d;
            in_ready               <= 1'b0;
            busy                   <= (state_d != IDLE);
            done                   <= 1'b0;
            sel1                   <= 1'b0;
            sel2                   <= 1'b0;
            sel3                   <= 1'b0;
            ld_text_wb             <= 1'b0;
            ldKey                  <= 1'b0;
            ldExpanded             <= 1'b0;
            ldTextAfterAddRoundKey <= 1'b0;
            ldTextAfterSubBytes    <= 1'b0;
            ldTextAfterShiftRows   <= 1'b0;
            case (state_d)
                IDLE:    in_ready <= 1'b1;
                KEYCAP: begin
                    ldKey <= 1'b1;
                    sel2  <= 1'b1;
                end
                WAITTXT: in_ready <= 1'b1;
                EXP:     ldExpanded <= 1'b1;
                ARK:     ldTextAfterAddRoundKey <= 1'b1;
                SUB:     ldTextAfterSubBytes <= 1'b1;
                SHR:     ldTextAfterShiftRows <= 1'b1;
                WB: begin
                    // Round 9 skips MixColumns: write back the ShiftRows result
                    ld_text_wb <= 1'b1;
                    sel1       <= 1'b1;
                    ldKey      <= 1'b1;
                    sel3       <= (round_d < LAST_MIX_ROUND);
                end
                FEXP:    ldExpanded <= 1'b1;
                FARK:    ldTextAfterAddRoundKey <= 1'b1;
                DONE:    done <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef AES_CTRL_CMP_CHECK_EN
    logic cmp_fail_c;
    logic unused_cmp;

    // The comparator must read "not final" in every WB and "final" in FEXP
    assign cmp_fail_c = ((state_q == WB) && equ) ||
                        ((state_q == FEXP) && (round_q == FINAL_ROUND) && !equ);
    assign unused_cmp = less ^ gt;

    // Sticky until reset; never disturbs the FSM flow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (cmp_fail_c) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_cmp;

    assign unused_cmp = equ ^ less ^ gt ^ (round_q == FINAL_ROUND);
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_aes_controller.sv
// tb_aes_controller: directed stimulus plus a scoreboard for aes_controller.
// The stimulus pushes one expected-result record per block it starts; a
// negedge monitor pops a record on every done pulse and compares latency,
// round, ldText count, WB sel3 pattern and err. Per-cycle protocol
// properties are also checked by the monitor.
module tb_aes_controller;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       equ;
    logic       less;
    logic       gt;
    logic       sel1, sel2, sel3;
    logic       ldText, ldKey, ldExpanded;
    logic       ldTextAfterAddRoundKey, ldTextAfterSubBytes, ldTextAfterShiftRows;
    logic       busy, done, err;
    logic [3:0] round;
    logic       inject;
    logic [16:0] outs;

    typedef struct {
        int   lat;
        int   rnd;
        int   nld;
        int   nsel3;
        int   nwb;
        logic err;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_acc  = 0;
    int n_ld   = 0;
    int n_sel3 = 0;
    int n_wb   = 0;
    bit have_key = 1'b0;
    bit key_pend = 1'b0;

    aes_controller dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .equ                    (equ),
        .less                   (less),
        .gt                     (gt),
        .sel1                   (sel1),
        .sel2                   (sel2),
        .sel3                   (sel3),
        .ldText                 (ldText),
        .ldKey                  (ldKey),
        .ldExpanded             (ldExpanded),
        .ldTextAfterAddRoundKey (ldTextAfterAddRoundKey),
        .ldTextAfterSubBytes    (ldTextAfterSubBytes),
        .ldTextAfterShiftRows   (ldTextAfterShiftRows),
        .busy                   (busy),
        .done                   (done),
        .round                  (round),
        .err                    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath comparator model: equ only in the final expansion, or when forced
    assign equ  = ((round == 4'd10) && ldExpanded) || (inject && sel1 && (round == 4'd3));
    assign less = 1'b0;
    assign gt   = 1'b0;

    assign outs = {in_ready, sel1, sel2, sel3, ldText, ldKey, ldExpanded,
                   ldTextAfterAddRoundKey, ldTextAfterSubBytes, ldTextAfterShiftRows,
                   busy, done, err, round};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            have_key = 1'b0;
            key_pend = 1'b0;
            n_ld     = 0;
            n_sel3   = 0;
            n_wb     = 0;
        end else begin
            if (key_pend) begin
                chk("keycap_ldkey", int'(ldKey), 1);
                chk("keycap_sel2", int'(sel2), 1);
                key_pend = 1'b0;
            end
            if (ldText) n_ld++;
            if (in_valid && in_ready) begin
                if (!have_key) begin
                    have_key = 1'b1;
                    key_pend = 1'b1;
                end else begin
                    t_acc = cyc + 1;
                end
            end
            if (sel1) begin
                n_wb++;
                chk("wb_sel3", int'(sel3), int'(round < 4'd9));
                chk("wb_ldkey", int'(ldKey & ~sel2), 1);
                if (sel3) n_sel3++;
            end
            if (ldExpanded || ldTextAfterAddRoundKey || ldTextAfterSubBytes ||
                ldTextAfterShiftRows || sel1 || done)
                chk("in_ready_while_running", int'(in_ready), 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_latency", cyc + 1 - t_acc, e.lat);
                    chk("done_round", int'(round), e.rnd);
                    chk("ldtext_count", n_ld, e.nld);
                    chk("wb_sel3_count", n_sel3, e.nsel3);
                    chk("wb_count", n_wb, e.nwb);
                    chk("done_err", int'(err), int'(e.err));
                end
                have_key = 1'b0;
                n_ld     = 0;
                n_sel3   = 0;
                n_wb     = 0;
            end
        end
    end

    // Inputs change 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_beat(output bit ok);
        int n;
        n = 0;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        ok = in_ready;
        tick();
        in_valid = 1'b0;
    endtask

    // Leaves the bench in the DONE cycle (or after the budget expires)
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        if (!done) chk(tag, 0, 1);
    endtask

    task automatic run_block(input int gap, input logic err_exp);
        bit ok;
        exp_q.push_back('{lat: 53, rnd: 10, nld: 12, nsel3: 9, nwb: 10, err: err_exp});
        send_beat(ok);
        chk("key_accept", int'(ok), 1);
        for (int i = 0; i < gap; i++) begin
            tick();
            chk("waittxt_ready", int'(in_ready), 1);
            chk("waittxt_no_load", int'(ldText | ldKey | ldExpanded | ldTextAfterAddRoundKey |
                                        ldTextAfterSubBytes | ldTextAfterShiftRows), 0);
        end
        send_beat(ok);
        chk("text_accept", int'(ok), 1);
        wait_done("done_timeout");
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit found;
        int dcount;
        in_valid = 1'b0;
        inject   = 1'b0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_outputs", int'(outs), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_reset", int'(in_ready), 1);
        chk("idle_not_busy", int'(busy), 0);
        chk("idle_round", int'(round), 0);

        // Back-to-back key and text
        run_block(0, 1'b0);
        // Text delayed 20 cycles
        run_block(20, 1'b0);

        // in_valid held high across two complete blocks
        exp_q.push_back('{lat: 53, rnd: 10, nld: 12, nsel3: 9, nwb: 10, err: 1'b0});
        exp_q.push_back('{lat: 53, rnd: 10, nld: 12, nsel3: 9, nwb: 10, err: 1'b0});
        in_valid = 1'b1;
        wait_done("cont_done1_timeout");
        tick();
        wait_done("cont_done2_timeout");
        in_valid = 1'b0;
        tick();
        chk("cont_back_idle", int'(in_ready & ~busy), 1);

        // Abort with reset in the round-5 SUB cycle
        send_beat(ok);
        send_beat(ok);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (round == 4'd5 && ldTextAfterSubBytes) found = 1'b1;
            else tick();
        end
        chk("reach_round5_sub", int'(found), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'(outs), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_abort", int'(in_ready), 1);
        chk("round_after_abort", int'(round), 0);
        dcount = 0;
        for (int i = 0; i < 70; i++) begin
            if (done) dcount++;
            tick();
        end
        chk("no_done_after_abort", dcount, 0);
        run_block(3, 1'b0);

`ifdef AES_CTRL_CMP_CHECK_EN
        // Forced comparator mismatch in the round-3 WB
        inject = 1'b1;
        run_block(0, 1'b1);
        inject = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("err_sticky", int'(err), 1);
        run_block(1, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("err_cleared_by_reset", int'(err), 0);
        tick();
        rst_n = 1'b1;
        tick();
`endif

        chk("pending_expectations", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_controller.md
AES_CONTROLLER -- requirements
Module: aes_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: a 128-bit beat is present on the datapath TextIn bus.
REQ-004 SHALL have port in_ready, output, 1 bit: the controller accepts a beat this cycle.
REQ-005 SHALL have ports equ, less, gt, input, 1 bit each: datapath round-comparator flags.
REQ-006 SHALL have ports sel1, sel2, sel3, output, 1 bit each. sel1: 0=TextIn, 1=TextBus feedback. sel2: 1=initial key from text register, 0=expanded-key feedback. sel3: 1=MixColumns result, 0=ShiftRows result.
REQ-007 SHALL have ports ldText, ldKey, ldExpanded, ldTextAfterAddRoundKey, ldTextAfterSubBytes, ldTextAfterShiftRows, output, 1 bit each: datapath register load enables.
REQ-008 SHALL have ports busy and done, output, 1 bit each; round, output, 4 bits: current round 0..10.
REQ-009 SHALL have port err, output, 1 bit: sticky comparator-mismatch flag (see Configuration).

Function
REQ-010 SHALL be a Moore FSM with states IDLE, KEYCAP, WAITTXT, EXP, ARK, SUB, SHR, WB, FEXP, FARK, DONE; all outputs decoded from state and round only.
REQ-011 IDLE: in_ready=1; in_valid (key beat) -> ldText=1, sel1=0 in the accepting cycle; next state KEYCAP.
REQ-012 KEYCAP: ldKey=1, sel2=1; next state WAITTXT.
REQ-013 WAITTXT: in_ready=1; in_valid (plaintext beat) -> ldText=1, sel1=0, round<=0; next state EXP. No in_valid -> stay in WAITTXT indefinitely.
REQ-014 Per round: EXP (ldExpanded=1) -> ARK (ldTextAfterAddRoundKey=1) -> SUB (ldTextAfterSubBytes=1) -> SHR (ldTextAfterShiftRows=1) -> WB; one cycle each.
REQ-015 WB: ldText=1, sel1=1, ldKey=1, sel2=0; sel3=1 when round<9, sel3=0 when round==9; round increments by 1.
REQ-016 WB with round==9 -> FEXP, else EXP. FEXP: ldExpanded=1 -> FARK: ldTextAfterAddRoundKey=1 -> DONE.
REQ-017 DONE: done=1 for exactly one cycle, then IDLE; the ciphertext is valid on the datapath in this cycle.
REQ-018 Latency: done SHALL assert exactly 53 cycles after the clock edge accepting the plaintext beat (50 round cycles + FEXP + FARK + 1).
REQ-019 busy=1 in every state except IDLE; in_ready=0 in every state except IDLE and WAITTXT.
REQ-020 in_valid outside IDLE/WAITTXT SHALL be ignored: no load and no state change.
REQ-021 At most one ld* enable per state, except the pairs defined in REQ-011, REQ-013 and REQ-015; sel outputs SHALL be 0 wherever this spec leaves them unspecified.
REQ-022 round SHALL never exceed 10 and SHALL be 4-bit unsigned with no wrap; it holds 10 through FEXP, FARK and DONE, and clears to 0 on re-entry to IDLE.

Reset
REQ-023 rst_n low SHALL force state IDLE asynchronously, with round=0; all ld*, sel*, busy, done and err=0; in_ready=0 while rst_n is low.
REQ-024 in_ready SHALL assert in the first cycle after rst_n deasserts.
REQ-025 Reset during any state, including mid-round, SHALL abandon the operation with no done pulse; a full key+text sequence is required afterwards.

Configuration
REQ-026 With macro AES_CTRL_CMP_CHECK_EN defined, in every WB and FEXP cycle equ SHALL be checked: equ==1 is required in the round==10 FEXP cycle and equ==0 in every WB cycle. Any violation SHALL set err, which stays set until reset; the FSM flow is unaffected.
REQ-027 Without AES_CTRL_CMP_CHECK_EN, err SHALL be constant 0 and equ/less/gt SHALL be unused.

Verification
REQ-028 Reset, then key beat then text beat back-to-back -> ldKey pulses in KEYCAP; done high exactly 53 cycles after text acceptance; round==10 at done.
REQ-029 Text beat delayed 20 cycles after key -> in_ready stays 1 in WAITTXT with no loads; latency to done still 53 cycles.
REQ-030 Count WB cycles -> sel3==1 in WB for rounds 0..8, sel3==0 only in the round-9 WB; ldText asserts 12 times total per block.
REQ-031 Hold in_valid=1 continuously -> beats accepted only in IDLE/WAITTXT; in_ready==0 throughout EXP..DONE.
REQ-032 Assert rst_n=0 mid-SUB in round 5 -> outputs zero immediately with no clock; no done; the next full sequence completes normally.
REQ-033 With AES_CTRL_CMP_CHECK_EN defined, drive equ=1 during a round-3 WB -> err=1 and stays 1 until reset; done is still produced on time.
